// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter
//   Round-robin arbiter sharing one registered output channel between N_REQ
//   valid/ready producers. Each cycle it picks the first valid requester at or
//   after the round-robin pointer, drives the shared mux select, and loads the
//   winning word into the output register. Sustains one transfer per clock.
//
// Ports
//   clk        in   1          clock, rising edge
//   rst_n      in   1          synchronous reset, active-low
//   in_valid   in   N_REQ      per-requester valid
//   in_data    in   N_REQ*W    packed data, requester i at [i*W +: W]
//   in_ready   out  N_REQ      per-requester ready, one-hot or zero
//   out_valid  out  1          registered output valid
//   out_data   out  W          registered winning data
//   out_id     out  ID_W       index of the requester that produced out_data
//   out_ready  in   1          consumer ready
//   sel        out  ID_W       combinational mux select (grant candidate)
module mux_rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int W     = 8,
    parameter int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   in_valid,
    input  logic [N_REQ*W-1:0] in_data,
    output logic [N_REQ-1:0]   in_ready,
    output logic               out_valid,
    output logic [W-1:0]       out_data,
    output logic [ID_W-1:0]    out_id,
    input  logic               out_ready,
    output logic [ID_W-1:0]    sel
);

    logic [ID_W-1:0] ptr_q, ptr_d;
    logic            out_valid_q, out_valid_d;
    logic [W-1:0]    out_data_q, out_data_d;
    logic [ID_W-1:0] out_id_q, out_id_d;

    logic [ID_W-1:0] grant;
    logic [ID_W-1:0] idx;
    logic            found;
    logic            acc;
    logic            xfer;
    logic [N_REQ-1:0] ready_vec;
    logic [W-1:0]    data_arr [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign data_arr[i] = in_data[i*W +: W];
    end

    // Rotating priority search starting at ptr_q; falls back to ptr_q when idle.
    always_comb begin
        grant = ptr_q;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = ID_W'((int'(ptr_q) + k) % N_REQ);
            if (!found && in_valid[idx]) begin
                grant = idx;
                found = 1'b1;
            end
        end
    end

    // Output register can take a word when empty or being drained this cycle.
    assign acc  = ~out_valid_q | out_ready;
    assign xfer = acc & (|in_valid) & rst_n;

    always_comb begin
        ready_vec = '0;
        if (xfer) begin
            ready_vec[grant] = 1'b1;
        end
    end

    always_comb begin
        ptr_d       = ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_id_d    = out_id_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = data_arr[grant];
            out_id_d    = grant;
            ptr_d       = (grant == ID_W'(N_REQ - 1)) ? '0 : grant + ID_W'(1);
        end else if (out_ready) begin
            // Drain without refill; out_data is left as-is since it is only
            // meaningful while out_valid is high.
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= '0;
        end else begin
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_id_q    <= out_id_d;
        end
    end

    assign in_ready  = ready_vec;
    assign sel       = grant;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_id    = out_id_q;

endmodule
